// File: rtl/jk_ff_pkg.sv
// Shared types and the single next-state function for the JK flip-flop bank.
// The op encoding is {J,K}, so a cell can cast its two inputs straight into jk_op_e.
package jk_ff_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_e;

    function automatic logic jk_next(input logic q, input jk_op_e op);
        logic nxt;
        case (op)
            JK_HOLD: nxt = q;
            JK_RST:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage : jk_ff_pkg

// File: rtl/jk_ff_bank_if.sv
// J/K/Q bundle of a jk_ff_bank; Qn joins the bundle only when JK_FF_QN_EN is defined.
// The master drives J/K and observes the state; the slave (the bank) owns the state outputs.
interface jk_ff_bank_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] Q;
`ifdef JK_FF_QN_EN
    logic [WIDTH-1:0] Qn;

    modport master (output J, output K, input Q, input Qn);
    modport slave  (input J, input K, output Q, output Qn);
`else
    modport master (output J, output K, input Q);
    modport slave  (input J, input K, output Q);
`endif
endinterface : jk_ff_bank_if

// File: rtl/jk_ff_cell.sv
// One JK flip-flop bit with a synchronous, active-high reset to rst_val.
// Next-state decoding is delegated entirely to jk_ff_pkg::jk_next.
module jk_ff_cell
    import jk_ff_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next state from the current bit and the {J,K} op.
    always_comb begin
        q_d = jk_next(q_q, jk_op_e'({j, k}));
    end

    // State register; reset wins over any J/K op in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : jk_ff_cell

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH independent JK flip-flops on one clock and synchronous reset.
// Defining JK_FF_QN_EN adds the complementary Qn output to the bus interface.
module jk_ff_bank #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    jk_ff_bank_if.slave    jk
);

    logic [WIDTH-1:0] q_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[i]),
            .j       (jk.J[i]),
            .k       (jk.K[i]),
            .q       (q_s[i])
        );
    end

    assign jk.Q = q_s;

`ifdef JK_FF_QN_EN
    // Complement taken from the register outputs, so it resets to ~RST_VAL.
    assign jk.Qn = ~q_s;
`endif

endmodule : jk_ff_bank

// File: tb/tb_jk_ff_bank.sv
// Self-checking bench: a 1-bit bank under directed truth-table steps and a 4-bit bank
// under random J/K, both compared against the JK characteristic equation Q+ = J&~Q | ~K&Q.
module tb_jk_ff_bank;

    localparam logic [3:0] RST4 = 4'b1010;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [0:0] m1;
    logic [3:0] m4;

    jk_ff_bank_if #(.WIDTH(1)) if1 ();
    jk_ff_bank_if #(.WIDTH(4)) if4 ();

    jk_ff_bank #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (.clk(clk), .rst(rst), .jk(if1));
    jk_ff_bank #(.WIDTH(4), .RST_VAL(RST4)) dut4 (.clk(clk), .rst(rst), .jk(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the reference model, then sample 1 ns after the edge.
    task automatic step();
        if (rst) begin
            m1 = 1'b0;
            m4 = RST4;
        end else begin
            m1 = (if1.J & ~m1) | (~if1.K & m1);
            m4 = (if4.J & ~m4) | (~if4.K & m4);
        end
        @(posedge clk);
        #1;
        check("q4_model", if4.Q, m4);
        check("q1_model", {3'b000, if1.Q}, {3'b000, m1});
`ifdef JK_FF_QN_EN
        check("qn4", if4.Qn, ~m4);
        check("qn1", {3'b000, if1.Qn}, {3'b000, ~m1});
`endif
        if4.J = 4'($urandom);
        if4.K = 4'($urandom);
    endtask

    task automatic drive1(input logic j, input logic k);
        if1.J = j;
        if1.K = k;
    endtask

    initial begin
        logic       start;
        int         n;
        logic [0:0] tgl_exp;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive1(1'b1, 1'b1);
        if4.J  = 4'b1111;
        if4.K  = 4'b1111;
        @(negedge clk);

        // Reset held two edges with J=K=1: reset overrides toggle.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_q1", {3'b000, if1.Q}, 4'b0000);
            check("rst_q4", if4.Q, RST4);
        end

        // First cycle out of reset: set on bank 1, mixed ops on bank 4.
        rst = 1'b0;
        drive1(1'b1, 1'b0);
        if4.J = 4'b0011;
        if4.K = 4'b0101;
        step();
        check("set_q1", {3'b000, if1.Q}, 4'b0001);
        check("mix_q4", if4.Q, 4'b1011);

        drive1(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_q1", {3'b000, if1.Q}, 4'b0001);
        end

        drive1(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_op_q1", {3'b000, if1.Q}, 4'b0000);
        end

        drive1(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("toggle_q1", {3'b000, if1.Q}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
        end

        // Reset mid-toggle sequence, then resume toggling.
        rst = 1'b1;
        step();
        check("mid_rst_q1", {3'b000, if1.Q}, 4'b0000);
        check("mid_rst_q4", if4.Q, RST4);
        rst = 1'b0;
        step();
        check("post_rst_q1", {3'b000, if1.Q}, 4'b0001);

        // J=K=1 held N cycles flips N times.
        for (int r = 0; r < 4; r++) begin
            start = if1.Q;
            n = int'($urandom_range(1, 9));
            for (int i = 0; i < n; i++) step();
            tgl_exp = start ^ 1'((n % 2) == 1);
            check("n_toggle_q1", {3'b000, if1.Q}, {3'b000, tgl_exp});
        end

        // Random ops on both banks with occasional reset.
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 15) == 0);
            drive1(1'($urandom), 1'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_jk_ff_bank
